mips_fetch_stage: RTL and testbench
===================================

// Module: mips_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the MIPS core: owns the PC, drives the word address into
//  the combinational instruction memory, and captures the returned word plus PC+4 into
//  the IF/ID register consumed by decode. Applies branch/jump redirects from later
//  stages and supports decode stall and flush. Counts retired fetches for debug.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  IMEM_AW    6              instruction-memory word-address width (64 words)
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   synchronous, active-high
//  stall          in   1   decode not ready: hold PC and IF/ID
//  branch_taken   in   1   redirect to branch_target (from execute)
//  branch_target  in   32  byte address of branch target
//  jump           in   1   redirect to J-type target (from decode)
//  jump_index     in   26  instr[25:0] of the jump in IF/ID
//  imem_addr      out  6   word address to instruction memory (= pc[7:2])
//  imem_rd        in   32  instruction word returned combinationally
//  pc             out  32  current fetch PC
//  if_instr       out  32  IF/ID instruction (0x00000000 = nop when invalid)
//  if_pc4         out  32  IF/ID PC+4 of if_instr
//  if_valid       out  1   IF/ID holds a real instruction
//  align_fault    out  1   sticky: a redirect target had [1:0] != 0
//  fetch_count    out  32  number of words captured into IF/ID, wraps at 2^32
// BEHAVIOUR
//  - Reset (sync, wins over everything): pc=RESET_PC, if_instr=0, if_pc4=0, if_valid=0,
//    align_fault=0, fetch_count=0, state=S_FILL.
//  - FSM: S_FILL (first cycle after reset, IF/ID empty) -> S_RUN; S_RUN -> S_HOLD when
//    stall and no redirect; S_HOLD -> S_RUN when stall drops or any redirect arrives.
//  - imem_addr = pc[IMEM_AW+1:2]; PC bits above wrap modulo 64 words, no fault.
//  - Next-PC priority: branch_taken > jump > stall(hold) > pc+4.
//  - Jump target = {if_pc4[31:28], jump_index, 2'b00}; taken only when if_valid=1.
//  - Redirect (branch or valid jump): pc <= target & ~32'h3; IF/ID flushed next edge
//    (if_valid=0, if_instr=0, if_pc4 unchanged); redirect overrides stall.
//    If target[1:0] != 0, align_fault <= 1 (sticky until reset).
//  - Normal advance (no stall, no redirect): if_instr <= imem_rd, if_pc4 <= pc+4,
//    if_valid <= 1, pc <= pc+4, fetch_count += 1. Latency imem_addr -> if_instr: 1 cycle.
//  - Stall without redirect: pc, if_instr, if_pc4, if_valid, fetch_count all hold.
//  - PC+4 arithmetic is 32-bit, wraps 0xFFFFFFFC -> 0x00000000.
//  - Reset mid-stall or mid-redirect: reset wins; pending redirect is discarded.
// STRUCTURE
//  - Shared package: RESET_PC default, NOP word 32'h0, FSM state encoding
//    (S_FILL, S_RUN, S_HOLD), IMEM_AW default.
//  - One sub-module: mips_next_pc (combinational priority mux + jump-target/align check).
//  - PC, IF/ID, FSM, fault and counter registers live in mips_fetch_stage.
// TESTING (bench instantiates imem loaded with the standard 18-word test program)
//  - Reset, release, 3 free cycles -> imem_addr 0,1,2; if_instr 0x20020005 (if_pc4=4),
//    then 0x2003000c (8), then 0x2067fff7 (12); fetch_count=3.
//  - Stall high 2 cycles at pc=0x10 -> pc, if_instr=0x00e22025, if_valid, fetch_count
//    unchanged; release -> if_instr=0x00642824, if_pc4=0x14.
//  - branch_taken with target 0x2C -> next edge if_valid=0, if_instr=0, pc=0x2C;
//    following edge if_instr=0x00853820, if_pc4=0x30.
//  - IF/ID holds 0x08000011 (if_pc4=0x40), jump=1, jump_index=0x11 -> pc=0x44, flush,
//    then if_instr=0xac020054; same with if_valid=0 -> jump ignored, pc+4.
//  - branch_taken+jump+stall same cycle, target 0x06 -> pc=0x04, align_fault=1, flush.
//  - Reset asserted during stall with pending branch -> pc=0, if_valid=0, fault=0, count=0.

Source files
------------

// File: rtl/mips_fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: reset defaults, the NOP word,
// FSM state encoding and the J-type target helper.
package mips_fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned IMEM_AW_DEFAULT  = 6;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_HOLD
  } fetch_state_e;

  // J-type target keeps the region bits of the delay-slot PC (PC+4 of the jump).
  function automatic logic [31:0] jump_target(input logic [3:0]  pc4_hi,
                                               input logic [25:0] index);
    return {pc4_hi, index, 2'b00};
  endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Next-PC selection for the fetch stage: branch > jump > stall hold > sequential,
// plus redirect-target alignment detection.
module mips_next_pc
  import mips_fetch_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [3:0]  pc4_hi,
  input  logic        if_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic        advance,
  output logic        misaligned
);

  logic        jump_take;
  logic [31:0] target;

  assign pc_plus4  = pc + 32'd4;
  // A jump is only meaningful when IF/ID holds a real instruction.
  assign jump_take = jump && if_valid;
  assign redirect  = branch_taken || jump_take;
  assign advance   = !redirect && !stall;

  always_comb begin
    target     = branch_taken ? branch_target : jump_target(pc4_hi, jump_index);
    misaligned = redirect && (target[1:0] != 2'b00);
    if (redirect) begin
      next_pc = target & ~32'h3;
    end else if (stall) begin
      next_pc = pc;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register, fill/run/hold FSM,
// sticky alignment fault and retired-fetch counter.
module mips_fetch_stage
  import mips_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_AW  = IMEM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rd,
  output logic [31:0]        pc,
  output logic [31:0]        if_instr,
  output logic [31:0]        if_pc4,
  output logic               if_valid,
  output logic               align_fault,
  output logic [31:0]        fetch_count
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q;
  logic [31:0] if_instr_q;
  logic [31:0] if_pc4_q;
  logic        if_valid_q;
  logic        align_fault_q;
  logic [31:0] fetch_count_q;

  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        advance;
  logic        misaligned;
  logic        if_live;

  // IF/ID is empty by construction in S_FILL, whatever the valid flag says.
  assign if_live = if_valid_q && (state_q != S_FILL);

  mips_next_pc u_next_pc (
    .pc            (pc_q),
    .pc4_hi        (if_pc4_q[31:28]),
    .if_valid      (if_live),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .next_pc       (next_pc),
    .pc_plus4      (pc_plus4),
    .redirect      (redirect),
    .advance       (advance),
    .misaligned    (misaligned)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FILL: state_d = S_RUN;
      S_RUN:  if (stall && !redirect) state_d = S_HOLD;
      S_HOLD: if (!stall || redirect) state_d = S_RUN;
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FILL;
      pc_q          <= RESET_PC;
      if_instr_q    <= NOP;
      if_pc4_q      <= 32'h0;
      if_valid_q    <= 1'b0;
      align_fault_q <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= next_pc;
      if (redirect) begin
        // Flush leaves if_pc4 alone so a later jump region lookup stays defined.
        if_instr_q <= NOP;
        if_valid_q <= 1'b0;
      end else if (advance) begin
        if_instr_q    <= imem_rd;
        if_pc4_q      <= pc_plus4;
        if_valid_q    <= 1'b1;
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (misaligned) begin
        align_fault_q <= 1'b1;
      end
    end
  end

  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign pc          = pc_q;
  assign if_instr    = if_instr_q;
  assign if_pc4      = if_pc4_q;
  assign if_valid    = if_valid_q;
  assign align_fault = align_fault_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage: a per-cycle vector table run against a model imem
// holding the 18-word test program, plus a hand sequence for stall straight out of reset.
module tb_mips_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        align_fault;
  logic [31:0] fetch_count;

  logic [31:0] imem [0:63];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rd = imem[imem_addr];

  mips_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .pc            (pc),
    .if_instr      (if_instr),
    .if_pc4        (if_pc4),
    .if_valid      (if_valid),
    .align_fault   (align_fault),
    .fetch_count   (fetch_count)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic        jmp;
    logic [25:0] idx;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_fault;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic stl, input logic br,
                              input logic [31:0] tgt, input logic jmp, input logic [25:0] idx,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic [31:0] e_pc4, input logic e_valid,
                              input logic e_fault, input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.tgt = tgt; v.jmp = jmp; v.idx = idx;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4;
    v.e_valid = e_valid; v.e_fault = e_fault; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pc4, input logic e_valid, input logic e_fault,
                           input logic [31:0] e_cnt);
    logic [31:0] e_addr;
    e_addr = {26'h0, e_pc[7:2]};
    chk({tag, " pc"}, pc, e_pc);
    chk({tag, " imem_addr"}, {26'h0, imem_addr}, e_addr);
    chk({tag, " if_instr"}, if_instr, e_instr);
    chk({tag, " if_pc4"}, if_pc4, e_pc4);
    chk({tag, " if_valid"}, {31'h0, if_valid}, {31'h0, e_valid});
    chk({tag, " align_fault"}, {31'h0, align_fault}, {31'h0, e_fault});
    chk({tag, " fetch_count"}, fetch_count, e_cnt);
  endtask

  task automatic drive(input logic rst, input logic stl, input logic br, input logic [31:0] tgt,
                       input logic jmp, input logic [25:0] idx);
    reset = rst; stall = stl; branch_taken = br; branch_target = tgt;
    jump = jmp; jump_index = idx;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    imem[0]  = 32'h20020005; imem[1]  = 32'h2003000c; imem[2]  = 32'h2067fff7;
    imem[3]  = 32'h00e22025; imem[4]  = 32'h00642824; imem[5]  = 32'h00a42820;
    imem[6]  = 32'h10a7000a; imem[7]  = 32'h0064202a; imem[8]  = 32'h10800001;
    imem[9]  = 32'h20050000; imem[10] = 32'h00e2202a; imem[11] = 32'h00853820;
    imem[12] = 32'h00e23822; imem[13] = 32'hac670044; imem[14] = 32'h8c020050;
    imem[15] = 32'h08000011; imem[16] = 32'h20020001; imem[17] = 32'hac020054;

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_index = 26'h0;

    //            rst stl br tgt           jmp idx    pc            instr         pc4     v f cnt
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 26'h0,  32'h0,        32'h0,        32'h0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  32'h4,        32'h20020005, 32'h4,  1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  32'h8,        32'h2003000c, 32'h8,  1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  32'hc,        32'h2067fff7, 32'hc,  1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  32'h10,       32'h00e22025, 32'h10, 1, 0, 4));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 26'h0,  32'h10,       32'h00e22025, 32'h10, 1, 0, 4));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 26'h0,  32'h10,       32'h00e22025, 32'h10, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  32'h14,       32'h00642824, 32'h14, 1, 0, 5));
    tbl.push_back(mk(0, 0, 1, 32'h2c,       0, 26'h0,  32'h2c,       32'h0,        32'h14, 0, 0, 5));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  32'h30,       32'h00853820, 32'h30, 1, 0, 6));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  32'h34,       32'h00e23822, 32'h34, 1, 0, 7));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  32'h38,       32'hac670044, 32'h38, 1, 0, 8));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  32'h3c,       32'h8c020050, 32'h3c, 1, 0, 9));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  32'h40,       32'h08000011, 32'h40, 1, 0, 10));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 26'h11, 32'h44,       32'h0,        32'h40, 0, 0, 10));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  32'h48,       32'hac020054, 32'h48, 1, 0, 11));
    tbl.push_back(mk(0, 0, 1, 32'h3c,       0, 26'h0,  32'h3c,       32'h0,        32'h48, 0, 0, 11));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 26'h11, 32'h40,       32'h08000011, 32'h40, 1, 0, 12));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 26'h11, 32'h44,       32'h0,        32'h40, 0, 0, 12));
    tbl.push_back(mk(0, 1, 1, 32'h6,        1, 26'h11, 32'h4,        32'h0,        32'h40, 0, 1, 12));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  32'h8,        32'h2003000c, 32'h8,  1, 1, 13));
    tbl.push_back(mk(1, 1, 1, 32'h20,       0, 26'h0,  32'h0,        32'h0,        32'h0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  32'h4,        32'h20020005, 32'h4,  1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 32'hfffffffc, 0, 26'h0,  32'hfffffffc, 32'h0,        32'h4,  0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  32'h0,        32'h0,        32'h0,  1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  32'h4,        32'h20020005, 32'h4,  1, 0, 3));

    @(negedge clk);
    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].rst, tbl[r].stl, tbl[r].br, tbl[r].tgt, tbl[r].jmp, tbl[r].idx);
      check_all($sformatf("row%0d", r), tbl[r].e_pc, tbl[r].e_instr, tbl[r].e_pc4,
                tbl[r].e_valid, tbl[r].e_fault, tbl[r].e_cnt);
    end

    // Stall held straight through reset release: nothing may be fetched until it drops.
    drive(1, 1, 0, 32'h0, 0, 26'h0);
    check_all("fill_rst", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 32'h0, 1, 26'h11);
    check_all("fill_stall0", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 32'h0, 0, 26'h0);
    check_all("fill_stall1", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 26'h0);
    check_all("fill_release", 32'h4, 32'h20020005, 32'h4, 1, 0, 1);
    drive(0, 0, 0, 32'h0, 0, 26'h0);
    check_all("fill_next", 32'h8, 32'h2003000c, 32'h8, 1, 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
